bias_stream_mem: RTL

- Parametrised, writable bias store for one FNN layer. It replaces a fixed constant bias table.
- Holds NUM_NEURONS signed two's-complement biases, loaded at run time through a write port.
- Has two read paths:
  - a random-access read port;
  - a streaming port with valid/ready handshake that feeds biases in index order to the neuron accumulate pipeline.

---
 rtl/fnn_pkg.sv | 15 +
 rtl/bias_stream_mem_if.sv | 40 ++++
 rtl/bias_regfile.sv | 58 +++++
 rtl/bias_stream_mem.sv | 106 ++++++++++
 4 files changed

// File: rtl/fnn_pkg.sv
// Shared FNN definitions: default widths, layer sizes, bias type and the
// stream FSM state encoding used by the bias store.
package fnn_pkg;

  localparam int FNN_DATA_W     = 8;
  localparam int HIDDEN_NEURONS = 30;

  typedef logic signed [FNN_DATA_W-1:0] bias_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } stream_state_t;

endpackage

// File: rtl/bias_stream_mem_if.sv
// Bundle of the write, random-read and streaming signals of the bias store.
// The design side uses the slave modport; the driving side uses master.
interface bias_stream_mem_if #(
  parameter int NUM_NEURONS = 30,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = $clog2(NUM_NEURONS)
);

  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic signed [DATA_W-1:0] wr_data;
  logic                     wr_err;

  logic                     rd_en;
  logic [ADDR_W-1:0]        rd_addr;
  logic signed [DATA_W-1:0] rd_data;
  logic                     rd_valid;

  logic                     start;
  logic                     busy;
  logic                     done;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0]        out_idx;
  logic                     out_last;

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr, start, out_ready,
    output wr_err, rd_data, rd_valid, busy, done, out_valid, out_data,
           out_idx, out_last
  );

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr, start, out_ready,
    input  wr_err, rd_data, rd_valid, busy, done, out_valid, out_data,
           out_idx, out_last
  );

endinterface

// File: rtl/bias_regfile.sv
// Flop-array bias storage with synchronous clear, one write port and two
// enabled, registered read-before-write read ports (out of range reads 0).
module bias_regfile #(
  parameter int NUM_NEURONS = 30,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = $clog2(NUM_NEURONS)
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic                     a_en,
  input  logic [ADDR_W-1:0]        a_addr,
  output logic signed [DATA_W-1:0] a_data,
  input  logic                     b_en,
  input  logic [ADDR_W-1:0]        b_addr,
  output logic signed [DATA_W-1:0] b_data
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(NUM_NEURONS);

  logic signed [DATA_W-1:0] mem [NUM_NEURONS];

  logic wr_ok;
  logic a_ok;
  logic b_ok;

  assign wr_ok = ({1'b0, wr_addr} < DEPTH);
  assign a_ok  = ({1'b0, a_addr} < DEPTH);
  assign b_ok  = ({1'b0, b_addr} < DEPTH);

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en && wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Both ports sample the pre-write contents, so a same-cycle write is unseen.
  always_ff @(posedge clk) begin
    if (srst) begin
      a_data <= '0;
      b_data <= '0;
    end else begin
      if (a_en) begin
        a_data <= a_ok ? mem[a_addr] : '0;
      end
      if (b_en) begin
        b_data <= b_ok ? mem[b_addr] : '0;
      end
    end
  end

endmodule

// File: rtl/bias_stream_mem.sv
// Writable bias store for one FNN layer: random-access read port plus an
// in-order valid/ready stream of all entries for the accumulate pipeline.
module bias_stream_mem
  import fnn_pkg::*;
#(
  parameter int NUM_NEURONS = HIDDEN_NEURONS,
  parameter int DATA_W      = FNN_DATA_W,
  parameter int ADDR_W      = $clog2(NUM_NEURONS)
) (
  input logic               clk,
  input logic               rst,
  bias_stream_mem_if.slave  bus
);

  localparam logic [ADDR_W:0]   DEPTH    = (ADDR_W+1)'(NUM_NEURONS);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);

  stream_state_t     state_reg, state_next;
  logic [ADDR_W-1:0] idx_reg, idx_next;
  logic              done_reg, done_next;
  logic              wr_err_reg;
  logic              rd_valid_reg;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;

  logic signed [DATA_W-1:0] rd_data_int;
  logic signed [DATA_W-1:0] out_data_int;

  bias_regfile #(
    .NUM_NEURONS (NUM_NEURONS),
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W)
  ) u_regfile (
    .clk     (clk),
    .srst    (rst),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .a_en    (bus.rd_en),
    .a_addr  (bus.rd_addr),
    .a_data  (rd_data_int),
    .b_en    (load_en),
    .b_addr  (load_addr),
    .b_data  (out_data_int)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      done_reg     <= 1'b0;
      wr_err_reg   <= 1'b0;
      rd_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      done_reg     <= done_next;
      wr_err_reg   <= bus.wr_en && ({1'b0, bus.wr_addr} >= DEPTH);
      rd_valid_reg <= bus.rd_en;
    end
  end

  // The beat register is loaded at the edge that hands off the previous beat,
  // which is what keeps held beats stable and lets later entries see writes.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    done_next  = 1'b0;
    load_en    = 1'b0;
    load_addr  = idx_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = STREAM;
          idx_next   = '0;
          load_en    = 1'b1;
          load_addr  = '0;
        end
      end
      STREAM: begin
        if (bus.out_ready) begin
          if (idx_reg == LAST_IDX) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            idx_next  = idx_reg + 1'b1;
            load_en   = 1'b1;
            load_addr = idx_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.wr_err    = wr_err_reg;
  assign bus.rd_data   = rd_data_int;
  assign bus.rd_valid  = rd_valid_reg;
  assign bus.busy      = (state_reg == STREAM);
  assign bus.done      = done_reg;
  assign bus.out_valid = (state_reg == STREAM);
  assign bus.out_data  = out_data_int;
  assign bus.out_idx   = idx_reg;
  assign bus.out_last  = (state_reg == STREAM) && (idx_reg == LAST_IDX);

endmodule
